// File: rtl/scr1_memif_pkg.sv
// Shared SCR1 memory-interface types: command and response encodings.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_imem_arb_idfifo.sv
// In-order FIFO of 1-bit master IDs, one entry per accepted-but-unanswered request.
module scr1_imem_arb_idfifo #(
  parameter int unsigned N_OUTSTD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic empty,
  output logic full
);

  localparam int unsigned PW = (N_OUTSTD > 1) ? $clog2(N_OUTSTD) : 1;
  localparam int unsigned CW = $clog2(N_OUTSTD + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N_OUTSTD - 1);

  logic [N_OUTSTD-1:0] id_q, id_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                push_en;
  logic                pop_en;

  // Pointers wrap at the FIFO depth, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(N_OUTSTD));
  assign head_id = id_q[rd_ptr_q];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      id_d[wr_ptr_q] = push_id;
      wr_ptr_d       = ptr_inc(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      id_q     <= id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule : scr1_imem_arb_idfifo

// File: rtl/scr1_imem_arb.sv
// Round-robin arbiter sharing one SCR1 imem port between the fetch unit (M0)
// and a debug/trace reader (M1); responses are steered back in issue order.
module scr1_imem_arb
  import scr1_memif_pkg::*;
#(
  parameter int unsigned N_OUTSTD = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_req_ack,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_resp,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_req_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_resp,
  output logic          s_req,
  output logic          s_cmd,
  output logic [AW-1:0] s_addr,
  input  logic          s_req_ack,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_resp,
  output logic          arb_err
);

  localparam logic SCR1_IMEM_ARB_M0 = 1'b0;
  localparam logic SCR1_IMEM_ARB_M1 = 1'b1;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic          lock_id_q, lock_id_d;
  logic          last_q, last_d;
  logic          arb_err_q, arb_err_d;

  logic          gnt_vld;
  logic          gnt_id;
  logic          gnt_req;
  logic [AW-1:0] gnt_addr;
  logic          accept;
  logic          resp_vld;
  logic          route;
  logic          fifo_head;
  logic          fifo_empty;
  logic          fifo_full;

  // Grant candidate: locked master first, then the single requester, then round-robin.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = SCR1_IMEM_ARB_M0;
    if (state_q == ARB_LOCKED) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (m0_req & m1_req) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_q;
    end else if (m0_req) begin
      gnt_vld = 1'b1;
      gnt_id  = SCR1_IMEM_ARB_M0;
    end else if (m1_req) begin
      gnt_vld = 1'b1;
      gnt_id  = SCR1_IMEM_ARB_M1;
    end
    gnt_req  = gnt_vld & ((gnt_id == SCR1_IMEM_ARB_M1) ? m1_req : m0_req);
    gnt_addr = (gnt_id == SCR1_IMEM_ARB_M1) ? m1_addr : m0_addr;
  end

  // Request path toward imem; everything is held quiet while reset is asserted.
  always_comb begin
    s_req      = rst_n & gnt_req & ~fifo_full;
    s_cmd      = 1'(SCR1_MEM_CMD_RD);
    s_addr     = gnt_vld ? gnt_addr : '0;
    accept     = s_req & s_req_ack;
    m0_req_ack = accept & (gnt_id == SCR1_IMEM_ARB_M0);
    m1_req_ack = accept & (gnt_id == SCR1_IMEM_ARB_M1);
  end

  // Response path: the oldest outstanding ID owns the response; data fans out to both.
  always_comb begin
    resp_vld = rst_n & (s_resp != 2'(SCR1_MEM_RESP_NOTRDY));
    route    = resp_vld & ~fifo_empty;
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    m0_resp  = 2'(SCR1_MEM_RESP_NOTRDY);
    m1_resp  = 2'(SCR1_MEM_RESP_NOTRDY);
    if (route && (fifo_head == SCR1_IMEM_ARB_M0)) begin
      m0_resp = s_resp;
    end
    if (route && (fifo_head == SCR1_IMEM_ARB_M1)) begin
      m1_resp = s_resp;
    end
  end

  // Lock holds the grant while a presented request waits for acceptance.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    arb_err_d = resp_vld & fifo_empty;
    unique case (state_q)
      ARB_OPEN: begin
        if (s_req & ~s_req_ack) begin
          state_d   = ARB_LOCKED;
          lock_id_d = gnt_id;
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          state_d = ARB_OPEN;
        end
      end
    endcase
    if (accept) begin
      last_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= SCR1_IMEM_ARB_M0;
      last_q    <= SCR1_IMEM_ARB_M1;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;

  scr1_imem_arb_idfifo #(
    .N_OUTSTD (N_OUTSTD)
  ) u_idfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_id (gnt_id),
    .pop     (resp_vld),
    .head_id (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule : scr1_imem_arb

// File: tb/tb_scr1_imem_arb.sv
// Self-checking bench for scr1_imem_arb: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_scr1_imem_arb;
  import scr1_memif_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_req_ack, m1_req_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    m0_resp, m1_resp;
  logic          s_req, s_cmd;
  logic [AW-1:0] s_addr;
  logic          s_req_ack;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_resp;
  logic          arb_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scr1_imem_arb #(.N_OUTSTD(N), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_req_ack (m0_req_ack),
    .m0_rdata   (m0_rdata),
    .m0_resp    (m0_resp),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_req_ack (m1_req_ack),
    .m1_rdata   (m1_rdata),
    .m1_resp    (m1_resp),
    .s_req      (s_req),
    .s_cmd      (s_cmd),
    .s_addr     (s_addr),
    .s_req_ack  (s_req_ack),
    .s_rdata    (s_rdata),
    .s_resp     (s_resp),
    .arb_err    (arb_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding IDs in issue order, last accepted master,
  // and the master currently presented but not yet accepted.
  bit mq[$];
  bit m_last    = 1'b1;
  bit m_pend    = 1'b0;
  bit m_pend_id = 1'b0;
  bit exp_err   = 1'b0;

  always @(negedge clk) begin : cmp_p
    bit            has, cid, creq, esreq, acc, rv, err_next;
    logic [AW-1:0] eaddr;
    logic [1:0]    e0, e1;
    e0 = 2'b00;
    e1 = 2'b00;
    chk("m_arb_err", 64'(arb_err), 64'(exp_err));
    chk("m_rdata", {m1_rdata, m0_rdata}, {s_rdata, s_rdata});
    chk("m_s_cmd", 64'(s_cmd), 64'd0);
    if (!rst_n) begin
      chk("m_rst_s_req", 64'(s_req), 64'd0);
      chk("m_rst_acks", 64'({m1_req_ack, m0_req_ack}), 64'd0);
      chk("m_rst_resp", 64'({m1_resp, m0_resp}), 64'd0);
      mq.delete();
      m_last  = 1'b1;
      m_pend  = 1'b0;
      exp_err = 1'b0;
    end else begin
      has = 1'b1;
      cid = 1'b0;
      if (m_pend)                cid = m_pend_id;
      else if (m0_req && m1_req) cid = !m_last;
      else if (m0_req)           cid = 1'b0;
      else if (m1_req)           cid = 1'b1;
      else                       has = 1'b0;
      creq  = has && (cid ? m1_req : m0_req);
      esreq = creq && (mq.size() < N);
      eaddr = has ? (cid ? m1_addr : m0_addr) : '0;
      acc   = esreq && s_req_ack;
      rv    = (s_resp != 2'b00);
      if (rv && mq.size() > 0) begin
        if (mq[0]) e1 = s_resp;
        else       e0 = s_resp;
      end
      chk("m_s_req", 64'(s_req), 64'(esreq));
      chk("m_s_addr", 64'(s_addr), 64'(eaddr));
      chk("m_acks", 64'({m1_req_ack, m0_req_ack}), 64'({acc && cid, acc && !cid}));
      chk("m_resp", 64'({m1_resp, m0_resp}), 64'({e1, e0}));
      err_next = rv && (mq.size() == 0);
      if (rv && mq.size() > 0) void'(mq.pop_front());
      if (acc) mq.push_back(cid);
      if (acc) begin
        m_pend = 1'b0;
        m_last = cid;
      end else if (esreq) begin
        m_pend    = 1'b1;
        m_pend_id = cid;
      end
      exp_err = err_next;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_req    = 1'b0;
    m1_req    = 1'b0;
    s_req_ack = 1'b0;
    s_resp    = 2'b00;
  endtask

  initial begin
    int out_cnt;
    bit a0, a1, acc;
    rst_n = 1'b0; m0_addr = '0; m1_addr = '0; s_rdata = '0;
    idle_in();

    // Outputs gated during reset even with live inputs.
    step(); m0_req = 1'b1; m0_addr = 32'h200; s_req_ack = 1'b1; s_resp = 2'b01;
    @(negedge clk);
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_acks", 64'({m1_req_ack, m0_req_ack}), 64'd0);
    chk("rst_resp", 64'({m1_resp, m0_resp}), 64'd0);
    step(); idle_in();

    // Single master request and response.
    step(); rst_n = 1'b1; m0_req = 1'b1; m0_addr = 32'h200; s_req_ack = 1'b1;
    @(negedge clk);
    chk("rst_err", 64'(arb_err), 64'd0);
    chk("single_addr", 64'(s_addr), 64'h200);
    chk("single_ack", 64'(m0_req_ack), 64'd1);
    step(); idle_in(); s_resp = 2'b01; s_rdata = 32'h00A52033;
    @(negedge clk);
    chk("single_resp", 64'({m1_resp, m0_resp}), 64'b0001);
    chk("single_rdata", 64'(m0_rdata), 64'h00A52033);
    step(); idle_in();

    // Tie from reset: alternating grants, responses follow one cycle later.
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      m0_req = 1'b1; m0_addr = 32'h1000; m1_req = 1'b1; m1_addr = 32'h2000;
      s_req_ack = 1'b1; s_resp = (k > 0) ? 2'b01 : 2'b00; s_rdata = 32'(k);
      @(negedge clk);
      chk("tie_addr", 64'(s_addr), (k % 2 == 0) ? 64'h1000 : 64'h2000);
      chk("tie_ack", 64'({m1_req_ack, m0_req_ack}), (k % 2 == 0) ? 64'b01 : 64'b10);
      if (k > 0) chk("tie_route", 64'({m1_resp, m0_resp}), (k % 2 == 1) ? 64'b0001 : 64'b0100);
    end
    step(); idle_in(); s_resp = 2'b01;
    @(negedge clk);
    chk("tie_route_last", 64'({m1_resp, m0_resp}), 64'b0100);

    // Make M0 the last grant so a tie would favour M1, then test the lock.
    step(); idle_in(); m0_req = 1'b1; m0_addr = 32'h111; s_req_ack = 1'b1;
    step(); idle_in(); s_resp = 2'b01;
    step(); idle_in(); m0_req = 1'b1; m0_addr = 32'h300;
    @(negedge clk);
    chk("lock_addr1", 64'(s_addr), 64'h300);
    step(); m1_req = 1'b1; m1_addr = 32'h400;
    @(negedge clk);
    chk("lock_addr2", 64'(s_addr), 64'h300);
    chk("lock_no_ack", 64'({m1_req_ack, m0_req_ack}), 64'd0);
    step();
    @(negedge clk);
    chk("lock_addr3", 64'(s_addr), 64'h300);
    step(); s_req_ack = 1'b1;
    @(negedge clk);
    chk("lock_ack_m0", 64'({m1_req_ack, m0_req_ack}), 64'b01);
    step(); m0_req = 1'b0;
    @(negedge clk);
    chk("lock_then_m1", 64'(s_addr), 64'h400);
    chk("lock_ack_m1", 64'({m1_req_ack, m0_req_ack}), 64'b10);

    // Full: two outstanding (M0 then M1), M1 asks again.
    step(); m1_addr = 32'h500;
    @(negedge clk);
    chk("full_s_req", 64'(s_req), 64'd0);
    chk("full_acks", 64'({m1_req_ack, m0_req_ack}), 64'd0);
    step(); s_resp = 2'b10; s_rdata = 32'hBAD;
    @(negedge clk);
    chk("full_err_route", 64'({m1_resp, m0_resp}), 64'b0010);
    step(); s_resp = 2'b00;
    @(negedge clk);
    chk("full_reopen", 64'(s_req), 64'd1);
    chk("full_reopen_ack", 64'({m1_req_ack, m0_req_ack}), 64'b10);

    // Drain to one, then same-cycle push and pop.
    step(); idle_in(); s_resp = 2'b01;
    @(negedge clk);
    chk("drain_m1", 64'({m1_resp, m0_resp}), 64'b0100);
    step(); m0_req = 1'b1; m0_addr = 32'h600; s_req_ack = 1'b1; s_resp = 2'b01;
    @(negedge clk);
    chk("pp_ack", 64'({m1_req_ack, m0_req_ack}), 64'b01);
    chk("pp_route_old", 64'({m1_resp, m0_resp}), 64'b0100);
    step(); idle_in(); s_resp = 2'b01;
    @(negedge clk);
    chk("pp_route_new", 64'({m1_resp, m0_resp}), 64'b0001);

    // Unexpected response with nothing outstanding.
    step(); idle_in(); s_resp = 2'b01;
    @(negedge clk);
    chk("unexp_resp", 64'({m1_resp, m0_resp}), 64'd0);
    chk("unexp_err_pre", 64'(arb_err), 64'd0);
    step(); idle_in();
    @(negedge clk);
    chk("unexp_err", 64'(arb_err), 64'd1);
    step();
    @(negedge clk);
    chk("unexp_err_clr", 64'(arb_err), 64'd0);

    // Reset with two outstanding discards them.
    step(); m0_req = 1'b1; m0_addr = 32'h700; m1_req = 1'b1; m1_addr = 32'h800; s_req_ack = 1'b1;
    @(negedge clk);
    chk("rr_ack_m1", 64'({m1_req_ack, m0_req_ack}), 64'b10);
    step(); m1_req = 1'b0;
    step(); idle_in(); rst_n = 1'b0;
    step(); rst_n = 1'b1; s_resp = 2'b01;
    @(negedge clk);
    chk("rst_flush_resp", 64'({m1_resp, m0_resp}), 64'd0);
    step(); idle_in();
    @(negedge clk);
    chk("rst_flush_err", 64'(arb_err), 64'd1);

    // Randomized traffic; masters hold requests until acknowledged.
    out_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      a0  = m0_req_ack;
      a1  = m1_req_ack;
      acc = s_req && s_req_ack;
      if (!rst_n) out_cnt = 0;
      else begin
        if (s_resp != 2'b00 && out_cnt > 0) out_cnt--;
        if (acc) out_cnt++;
      end
      step();
      rst_n = ($urandom_range(0, 499) != 0);
      if (!m0_req || a0) begin m0_req = ($urandom_range(0, 99) < 55); m0_addr = $urandom; end
      if (!m1_req || a1) begin m1_req = ($urandom_range(0, 99) < 55); m1_addr = $urandom; end
      s_req_ack = ($urandom_range(0, 99) < 50);
      if (out_cnt > 0 && $urandom_range(0, 99) < 45) s_resp = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      else if ($urandom_range(0, 99) < 3)            s_resp = 2'b01;
      else                                           s_resp = 2'b00;
      s_rdata = $urandom;
    end

    step(); idle_in();
    step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_scr1_imem_arb
